// File: rtl/act_buf_pkg.sv
// Shared constants and types for the ping-pong activation buffer.
// One bank holds a full layer output frame of signed 6.10 words.
package act_buf_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 11;
   localparam int DEPTH  = 1152;

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   typedef logic signed [15:0] word_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_RST,
      P_SETTLE,
      P_RUN
   } prod_state_t;

   typedef enum logic [1:0] {
      C_IDLE,
      C_RST,
      C_SETTLE,
      C_RUN
   } cons_state_t;

endpackage

// File: rtl/act_bank_ram.sv
// Single activation bank: one write port, one read port, read data registered.
// Contents are not reset; frames are always rewritten before they are read.
module act_bank_ram #(
   parameter int NUM_WORDS = 1152,
   parameter int WORD_W    = 16,
   parameter int ADDR_BITS = 11
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WORD_W-1:0]    wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WORD_W-1:0]    rdata
);

   logic [WORD_W-1:0] mem [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/act_pingpong_buffer.sv
// Double-banked activation buffer between a producer and a consumer layer engine.
// The producer fills bank wb while the consumer drains bank rb; full[] hands banks over.
module act_pingpong_buffer
   import act_buf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              src_valid,
   output logic              prod_reset,
   output logic              prod_valid,
   input  logic              prod_done,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_we,
   output logic              cons_reset,
   output logic              cons_valid,
   input  logic              cons_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [15:0]       frames_out,
   output logic              err_short
);

   prod_state_t       p_state, p_next;
   cons_state_t       c_state, c_next;
   logic              wb, rb, rb_q, rd_blank;
   logic [1:0]        full, full_next;
   logic [ADDR_W-1:0] wr_count;
   logic              wr_ok, p_finish, c_finish;
   word_t             bank_q [2];

   assign wr_ok    = (p_state == P_RUN) && wr_we && (wr_addr < DEPTH_A);
   assign p_finish = (p_state == P_RUN) && prod_done;
   assign c_finish = (c_state == C_RUN) && cons_done;

   // Producer sequencing: restart pulse, one settle cycle to absorb the stale done, then run.
   always_comb begin
      p_next     = p_state;
      prod_reset = 1'b0;
      prod_valid = 1'b0;
      case (p_state)
         P_IDLE:   if (src_valid && !full[wb]) p_next = P_RST;
         P_RST:    begin
                      prod_reset = 1'b1;
                      p_next     = P_SETTLE;
                   end
         P_SETTLE: p_next = P_RUN;
         P_RUN:    begin
                      prod_valid = 1'b1;
                      if (prod_done) p_next = P_IDLE;
                   end
         default:  p_next = P_IDLE;
      endcase
   end

   // Consumer sequencing mirrors the producer but starts whenever its bank is full.
   always_comb begin
      c_next     = c_state;
      cons_reset = 1'b0;
      cons_valid = 1'b0;
      case (c_state)
         C_IDLE:   if (full[rb]) c_next = C_RST;
         C_RST:    begin
                      cons_reset = 1'b1;
                      c_next     = C_SETTLE;
                   end
         C_SETTLE: c_next = C_RUN;
         C_RUN:    begin
                      cons_valid = 1'b1;
                      if (cons_done) c_next = C_IDLE;
                   end
         default:  c_next = C_IDLE;
      endcase
   end

   // Set and clear always target different banks, so both may land in one cycle.
   always_comb begin
      full_next = full;
      if (p_finish) full_next[wb] = 1'b1;
      if (c_finish) full_next[rb] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_state    <= P_IDLE;
         c_state    <= C_IDLE;
         wb         <= 1'b0;
         rb         <= 1'b0;
         full       <= 2'b00;
         wr_count   <= '0;
         err_short  <= 1'b0;
         frames_out <= '0;
         rb_q       <= 1'b0;
         rd_blank   <= 1'b1;
      end else begin
         p_state  <= p_next;
         c_state  <= c_next;
         full     <= full_next;
         rb_q     <= rb;
         rd_blank <= (rd_addr >= DEPTH_A);
         if (p_finish) begin
            wb        <= ~wb;
            wr_count  <= '0;
            err_short <= err_short | (wr_count != DEPTH_A);
         end else if (wr_ok && (wr_count != DEPTH_A)) begin
            wr_count <= wr_count + 1'b1;
         end
         if (c_finish) begin
            rb <= ~rb;
         end
         if (c_state == C_SETTLE) begin
            frames_out <= frames_out + 16'd1;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [DATA_W-1:0] q;

      act_bank_ram #(
         .NUM_WORDS(DEPTH),
         .WORD_W   (DATA_W),
         .ADDR_BITS(ADDR_W)
      ) u_ram (
         .clk  (clk),
         .we   (wr_ok && (wb == 1'(b))),
         .waddr(wr_addr),
         .wdata(wr_data),
         .raddr(rd_addr),
         .rdata(q)
      );

      assign bank_q[b] = word_t'(q);
   end

   assign rd_data = rd_blank ? '0 : bank_q[rb_q];

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Scenario bench for act_pingpong_buffer: random frame data tracked in a two-bank
// reference model, handshake timing checked against the documented latencies.
module tb_act_pingpong_buffer;
   import act_buf_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              src_valid = 1'b0;
   logic              prod_done = 1'b0;
   logic              cons_done = 1'b0;
   logic              wr_we = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              prod_reset, prod_valid, cons_reset, cons_valid, err_short;
   logic [DATA_W-1:0] rd_data;
   logic [15:0]       frames_out;

   int n_checks = 0;
   int n_fail = 0;

   logic [DATA_W-1:0] mdl_bank [2][DEPTH];
   int mdl_wb = 0;
   int mdl_rb = 0;
   int mdl_frames = 0;
   bit mdl_err = 1'b0;

   act_pingpong_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .src_valid (src_valid),
      .prod_reset(prod_reset),
      .prod_valid(prod_valid),
      .prod_done (prod_done),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_we     (wr_we),
      .cons_reset(cons_reset),
      .cons_valid(cons_valid),
      .cons_done (cons_done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .frames_out(frames_out),
      .err_short (err_short)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic sel_out(input int which);
      case (which)
         0:       return prod_reset;
         1:       return prod_valid;
         2:       return cons_reset;
         default: return cons_valid;
      endcase
   endfunction

   // Waits up to limit cycles for the chosen handshake output; cycles=-1 on timeout.
   task automatic wait_sig(input int which, input int limit, output int cycles);
      cycles = -1;
      for (int c = 0; c <= limit; c++) begin
         if (sel_out(which)) begin
            cycles = c;
            break;
         end
         if (c < limit) tick();
      end
   endtask

   task automatic read_word(input int addr, output logic [DATA_W-1:0] data);
      rd_addr = ADDR_W'(addr);
      tick();
      data = rd_data;
   endtask

   function automatic logic [DATA_W-1:0] exp_read(input int addr);
      if (addr >= DEPTH) return '0;
      return mdl_bank[mdl_rb][addr];
   endfunction

   // Emulates the producer engine writing n words plus dropped out-of-range noise.
   task automatic produce(input int n, input bit addr_data, input bit with_cons);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(7) == 0) begin
            wr_we   = 1'b1;
            wr_addr = ADDR_W'($urandom_range(2047, DEPTH));
            wr_data = DATA_W'($urandom);
            tick();
         end
         wr_we   = 1'b1;
         wr_addr = ADDR_W'(i);
         wr_data = addr_data ? DATA_W'(i) : DATA_W'($urandom);
         mdl_bank[mdl_wb][i] = wr_data;
         tick();
      end
      wr_we     = 1'b0;
      prod_done = 1'b1;
      cons_done = with_cons;
      tick();
      prod_done = 1'b0;
      cons_done = 1'b0;
      mdl_wb   ^= 1;
      mdl_err  |= (n != DEPTH);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      n_checks++;
      if ({prod_reset, prod_valid, cons_reset, cons_valid, err_short} !== 5'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b expected 00000",
                  {prod_reset, prod_valid, cons_reset, cons_valid, err_short});
      end
      n_checks++;
      if (frames_out !== 16'd0 || rd_data !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_data: frames_out=%0d rd_data=%0d expected 0 0", frames_out, rd_data);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fill_frame();
      logic got;
      src_valid = 1'b1;
      tick();
      got = prod_reset;
      n_checks++;
      if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL prod_reset_rise: got %b expected 1", got); end
      src_valid = 1'b0;
      tick();
      n_checks++;
      if ({prod_reset, prod_valid} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL settle_cycle: got reset/valid=%b expected 00", {prod_reset, prod_valid});
      end
      tick();
      n_checks++;
      if (prod_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL prod_valid_rise: got %b expected 1", prod_valid); end
      produce(DEPTH, 1'b1, 1'b0);
      n_checks++;
      if (prod_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL prod_valid_drop: got %b expected 0", prod_valid); end
      tick();
      n_checks++;
      if (cons_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL cons_reset_rise: got %b expected 1", cons_reset); end
      tick();
      n_checks++;
      if ({cons_reset, cons_valid} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL cons_settle: got reset/valid=%b expected 00", {cons_reset, cons_valid});
      end
      tick();
      mdl_frames++;
      n_checks++;
      if (cons_valid !== 1'b1 || frames_out !== 16'(mdl_frames)) begin
         n_fail++;
         $display("[TB] FAIL cons_start: cons_valid=%b frames_out=%0d expected 1 %0d",
                  cons_valid, frames_out, mdl_frames);
      end
   endtask

   task automatic test_read();
      int addrs [4] = '{5, 1151, 1200, 0};
      int a;
      logic [DATA_W-1:0] d;
      for (int k = 0; k < 16; k++) begin
         a = (k < 4) ? addrs[k] : int'($urandom_range(1300));
         read_word(a, d);
         n_checks++;
         if (d !== exp_read(a)) begin
            n_fail++;
            $display("[TB] FAIL read addr %0d: got %0d expected %0d", a, d, exp_read(a));
         end
      end
      cons_done = 1'b1;
      tick();
      cons_done = 1'b0;
      mdl_rb ^= 1;
      n_checks++;
      if (cons_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL cons_release: got %b expected 0", cons_valid); end
   endtask

   task automatic test_short_frame();
      int cyc, a;
      logic [DATA_W-1:0] d;
      src_valid = 1'b1;
      wait_sig(0, 4, cyc);
      src_valid = 1'b0;
      wait_sig(1, 4, cyc);
      n_checks++;
      if (cyc < 0) begin n_fail++; $display("[TB] FAIL short_start: got timeout expected prod_valid"); end
      produce(1000, 1'b0, 1'b0);
      n_checks++;
      if (err_short !== mdl_err) begin n_fail++; $display("[TB] FAIL err_short_set: got %b expected %b", err_short, mdl_err); end
      wait_sig(3, 6, cyc);
      mdl_frames++;
      n_checks++;
      if (cyc < 0 || frames_out !== 16'(mdl_frames)) begin
         n_fail++;
         $display("[TB] FAIL short_handoff: cycles=%0d frames_out=%0d expected %0d", cyc, frames_out, mdl_frames);
      end
      for (int k = 0; k < 8; k++) begin
         a = int'($urandom_range(999));
         read_word(a, d);
         n_checks++;
         if (d !== exp_read(a)) begin n_fail++; $display("[TB] FAIL short_read addr %0d: got %0d expected %0d", a, d, exp_read(a)); end
      end
      cons_done = 1'b1;
      tick();
      cons_done = 1'b0;
      mdl_rb ^= 1;
      repeat (10) tick();
      n_checks++;
      if (err_short !== 1'b1) begin n_fail++; $display("[TB] FAIL err_short_sticky: got %b expected 1", err_short); end
   endtask

   task automatic test_back_to_back();
      int cyc, hits, a;
      int stall_addr [$];
      logic [DATA_W-1:0] d;
      src_valid = 1'b1;
      wait_sig(1, 6, cyc);
      produce(DEPTH, 1'b0, 1'b0);
      mdl_frames++;
      wait_sig(1, 6, cyc);
      n_checks++;
      if (cyc < 0) begin n_fail++; $display("[TB] FAIL second_start: got timeout expected prod_valid"); end
      produce(DEPTH, 1'b0, 1'b0);
      hits = 0;
      prod_done = 1'b1;
      for (int k = 0; k < 30; k++) begin
         wr_we   = 1'b1;
         wr_addr = ADDR_W'($urandom_range(DEPTH - 1));
         wr_data = DATA_W'($urandom);
         stall_addr.push_back(int'(wr_addr));
         tick();
         if (prod_reset) hits++;
      end
      wr_we     = 1'b0;
      prod_done = 1'b0;
      n_checks++;
      if (hits != 0) begin n_fail++; $display("[TB] FAIL stall_withheld: got %0d prod_reset cycles expected 0", hits); end
      n_checks++;
      if (cons_valid !== 1'b1 || frames_out !== 16'(mdl_frames)) begin
         n_fail++;
         $display("[TB] FAIL stall_consumer: cons_valid=%b frames_out=%0d expected 1 %0d", cons_valid, frames_out, mdl_frames);
      end
      for (int k = 0; k < 4; k++) begin
         a = stall_addr[k];
         read_word(a, d);
         n_checks++;
         if (d !== exp_read(a)) begin n_fail++; $display("[TB] FAIL stall_write_dropped addr %0d: got %0d expected %0d", a, d, exp_read(a)); end
      end
      cons_done = 1'b1;
      tick();
      cons_done = 1'b0;
      mdl_rb ^= 1;
      mdl_frames++;
      wait_sig(0, 2, cyc);
      n_checks++;
      if (cyc < 0) begin n_fail++; $display("[TB] FAIL unstall_restart: got timeout expected prod_reset within 2"); end
   endtask

   task automatic test_simultaneous();
      int cyc, a;
      logic [DATA_W-1:0] d;
      wait_sig(1, 4, cyc);
      src_valid = 1'b0;
      wait_sig(3, 4, cyc);
      n_checks++;
      if (cyc < 0 || frames_out !== 16'(mdl_frames)) begin
         n_fail++;
         $display("[TB] FAIL both_running: cycles=%0d frames_out=%0d expected %0d", cyc, frames_out, mdl_frames);
      end
      produce(DEPTH, 1'b0, 1'b1);
      mdl_rb ^= 1;
      n_checks++;
      if ({prod_valid, cons_valid} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL both_idle: got valids=%b expected 00", {prod_valid, cons_valid});
      end
      tick();
      n_checks++;
      if ({prod_reset, cons_reset} !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL simul_restart: got prod/cons reset=%b expected 01", {prod_reset, cons_reset});
      end
      mdl_frames++;
      src_valid = 1'b1;
      wait_sig(0, 2, cyc);
      n_checks++;
      if (cyc < 0) begin n_fail++; $display("[TB] FAIL simul_prod_free: got timeout expected prod_reset"); end
      wait_sig(1, 4, cyc);
      src_valid = 1'b0;
      n_checks++;
      if (frames_out !== 16'(mdl_frames)) begin n_fail++; $display("[TB] FAIL simul_frames: got %0d expected %0d", frames_out, mdl_frames); end
      for (int k = 0; k < 6; k++) begin
         a = int'($urandom_range(DEPTH - 1));
         read_word(a, d);
         n_checks++;
         if (d !== exp_read(a)) begin n_fail++; $display("[TB] FAIL simul_read addr %0d: got %0d expected %0d", a, d, exp_read(a)); end
      end
      produce(DEPTH, 1'b0, 1'b0);
      cons_done = 1'b1;
      tick();
      cons_done = 1'b0;
      mdl_rb ^= 1;
      wait_sig(3, 6, cyc);
      mdl_frames++;
      n_checks++;
      if (cyc < 0 || frames_out !== 16'(mdl_frames)) begin
         n_fail++;
         $display("[TB] FAIL next_handoff: cycles=%0d frames_out=%0d expected %0d", cyc, frames_out, mdl_frames);
      end
      for (int k = 0; k < 6; k++) begin
         a = int'($urandom_range(DEPTH - 1));
         read_word(a, d);
         n_checks++;
         if (d !== exp_read(a)) begin n_fail++; $display("[TB] FAIL bank1_read addr %0d: got %0d expected %0d", a, d, exp_read(a)); end
      end
   endtask

   task automatic test_reset_mid();
      int cyc, a;
      logic [DATA_W-1:0] d;
      src_valid = 1'b1;
      wait_sig(1, 6, cyc);
      n_checks++;
      if (cyc < 0) begin n_fail++; $display("[TB] FAIL mid_start: got timeout expected prod_valid"); end
      for (int i = 0; i < 300; i++) begin
         wr_we   = 1'b1;
         wr_addr = ADDR_W'(i);
         wr_data = DATA_W'($urandom);
         tick();
      end
      wr_we = 1'b0;
      reset = 1'b1;
      tick();
      n_checks++;
      if ({prod_reset, prod_valid, cons_reset, cons_valid, err_short} !== 5'b0 || frames_out !== 16'd0 || rd_data !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset: flags=%b frames_out=%0d rd_data=%0d expected 00000 0 0",
                  {prod_reset, prod_valid, cons_reset, cons_valid, err_short}, frames_out, rd_data);
      end
      mdl_wb = 0;
      mdl_rb = 0;
      mdl_frames = 0;
      mdl_err = 1'b0;
      reset = 1'b0;
      wait_sig(0, 3, cyc);
      n_checks++;
      if (cyc < 0) begin n_fail++; $display("[TB] FAIL post_reset_pulse: got timeout expected prod_reset"); end
      src_valid = 1'b0;
      wait_sig(1, 4, cyc);
      produce(852, 1'b0, 1'b0);
      n_checks++;
      if (err_short !== mdl_err) begin n_fail++; $display("[TB] FAIL count_restart: got err_short=%b expected %b", err_short, mdl_err); end
      wait_sig(3, 6, cyc);
      mdl_frames++;
      n_checks++;
      if (cyc < 0 || frames_out !== 16'(mdl_frames)) begin
         n_fail++;
         $display("[TB] FAIL post_reset_frames: cycles=%0d frames_out=%0d expected %0d", cyc, frames_out, mdl_frames);
      end
      for (int k = 0; k < 6; k++) begin
         a = int'($urandom_range(851));
         read_word(a, d);
         n_checks++;
         if (d !== exp_read(a)) begin n_fail++; $display("[TB] FAIL post_reset_read addr %0d: got %0d expected %0d", a, d, exp_read(a)); end
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_fill_frame();
      test_read();
      test_short_frame();
      test_back_to_back();
      test_simultaneous();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
